// File: rtl/gba_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module : gba_ram_pkg
// Brief  : Shared widths, FSM states and response beat type for the block RAM
//          burst initiator.
// Rev    : 1.0  initial release
// ============================================================================
package gba_ram_pkg;

  localparam int unsigned c_addr_w = 17;
  localparam int unsigned c_data_w = 9;
  localparam int unsigned c_len_w  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  typedef struct packed {
    logic [c_data_w-1:0] data;
    logic                last;
    logic                err;
  } rsp_beat_t;

endpackage
`default_nettype wire

// File: rtl/blk_ram_burst_initiator_if.sv
`default_nettype none
// ============================================================================
// Module : blk_ram_burst_initiator_if
// Brief  : Request, write-beat, response and RAM-port signals of the burst
//          initiator; slave = initiator block, master = engine/RAM side.
// Rev    : 1.0  initial release
// ============================================================================
interface blk_ram_burst_initiator_if
  import gba_ram_pkg::*;
#(
  parameter int ADDR_W = c_addr_w,
  parameter int DATA_W = c_data_w,
  parameter int LEN_W  = c_len_w
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              rsp_err;
  logic              busy;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  req_valid, req_write, req_addr, req_len,
    input  wr_valid, wr_data, rsp_ready, ram_dout,
    output req_ready, wr_ready, rsp_valid, rsp_data, rsp_last, rsp_err,
    output busy, ram_en, ram_we, ram_addr, ram_din
  );

  modport master (
    output req_valid, req_write, req_addr, req_len,
    output wr_valid, wr_data, rsp_ready, ram_dout,
    input  req_ready, wr_ready, rsp_valid, rsp_data, rsp_last, rsp_err,
    input  busy, ram_en, ram_we, ram_addr, ram_din
  );

endinterface
`default_nettype wire

// File: rtl/ram_rsp_fifo2.sv
`default_nettype none
// ============================================================================
// Module : ram_rsp_fifo2
// Brief  : 2-entry synchronous response FIFO with a registered head entry.
// Rev    : 1.0  initial release
// ============================================================================
module ram_rsp_fifo2
  import gba_ram_pkg::*;
(
  input  logic      clk,
  input  logic      reset_l,
  input  logic      push,
  input  rsp_beat_t push_beat,
  input  logic      pop,
  output logic [1:0] count,
  output rsp_beat_t head
);

  rsp_beat_t  r_head;
  rsp_beat_t  r_tail;
  logic [1:0] r_count;
  logic       w_pop;

  assign w_pop = pop & (r_count != 2'd0);

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case ({push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head  <= push_beat;
            r_count <= 2'd1;
          end else if (r_count == 2'd1) begin
            r_tail  <= push_beat;
            r_count <= 2'd2;
          end
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new beat lands behind whatever remains.
          if (r_count == 2'd1) begin
            r_head <= push_beat;
          end else begin
            r_head <= r_tail;
            r_tail <= push_beat;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = r_count;
  assign head  = r_head;

endmodule
`default_nettype wire

// File: rtl/blk_ram_burst_initiator.sv
`default_nettype none
// ============================================================================
// Module : blk_ram_burst_initiator
// Brief  : Burst read/write initiator for the 128kx9 single-port block RAM.
//          Optional macro RAM_PARITY_EN: 8-bit data + even parity in bit 8.
// Rev    : 1.0  initial release
// ============================================================================
module blk_ram_burst_initiator
  import gba_ram_pkg::*;
#(
  parameter int ADDR_W = c_addr_w,
  parameter int DATA_W = c_data_w,
  parameter int LEN_W  = c_len_w
) (
  input  logic clk,
  input  logic reset_l,
  blk_ram_burst_initiator_if.slave bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_din;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_inflight;
  logic              r_inflight_last;

  logic              w_req_ready;
  logic              w_wr_ready;
  logic              w_issue_rd;
  logic              w_issue_wr;
  logic              w_issue;
  logic              w_accept;
  logic              w_last_beat;
  logic              w_pop;
  logic [1:0]        w_fifo_count;
  logic [1:0]        w_occ;
  logic [DATA_W-1:0] w_wr_din;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_rd_err;
  rsp_beat_t         w_push_beat;
  rsp_beat_t         w_head;

`ifdef RAM_PARITY_EN
  logic w_unused_wr_msb;
  assign w_wr_din        = {^bus.wr_data[DATA_W-2:0], bus.wr_data[DATA_W-2:0]};
  assign w_rd_data       = {1'b0, bus.ram_dout[DATA_W-2:0]};
  assign w_rd_err        = ^bus.ram_dout;
  assign w_unused_wr_msb = bus.wr_data[DATA_W-1];
`else
  assign w_wr_din  = bus.wr_data;
  assign w_rd_data = bus.ram_dout;
  assign w_rd_err  = 1'b0;
`endif

  assign w_last_beat = (r_cnt == r_len);
  assign w_pop       = (w_fifo_count != 2'd0) & bus.rsp_ready;
  // Slots that will be occupied once the pending read lands, net of this cycle's pop.
  assign w_occ       = w_fifo_count + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_accept    = w_req_ready & bus.req_valid;
  assign w_issue     = w_issue_rd | w_issue_wr;

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_wr_ready  = 1'b0;
    w_issue_rd  = 1'b0;
    w_issue_wr  = 1'b0;
    if (reset_l) begin
      case (r_state)
        IDLE: begin
          w_req_ready = 1'b1;
          if (bus.req_valid) begin
            w_state_nxt = bus.req_write ? WR : RD;
          end
        end
        RD: begin
          if (w_occ < 2'd2) begin
            w_issue_rd = 1'b1;
            if (w_last_beat) begin
              w_state_nxt = IDLE;
            end
          end
        end
        WR: begin
          w_wr_ready = 1'b1;
          if (bus.wr_valid) begin
            w_issue_wr = 1'b1;
            if (w_last_beat) begin
              w_state_nxt = IDLE;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_state         <= IDLE;
      r_addr          <= '0;
      r_ram_addr      <= '0;
      r_ram_din       <= '0;
      r_len           <= '0;
      r_cnt           <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_inflight      <= w_issue_rd;
      r_inflight_last <= w_issue_rd & w_last_beat;
      if (w_accept) begin
        r_addr <= bus.req_addr;
        r_len  <= bus.req_len;
        r_cnt  <= '0;
      end else if (w_issue) begin
        r_addr     <= r_addr + ADDR_W'(1);
        r_cnt      <= r_cnt + LEN_W'(1);
        r_ram_addr <= r_addr;
      end
      if (w_issue_wr) begin
        r_ram_din <= w_wr_din;
      end
    end
  end

  assign w_push_beat = '{data: w_rd_data, last: r_inflight_last, err: w_rd_err};

  ram_rsp_fifo2 u_rsp_fifo (
    .clk       (clk),
    .reset_l   (reset_l),
    .push      (r_inflight),
    .push_beat (w_push_beat),
    .pop       (w_pop),
    .count     (w_fifo_count),
    .head      (w_head)
  );

  assign bus.req_ready = w_req_ready;
  assign bus.wr_ready  = w_wr_ready;
  assign bus.ram_en    = w_issue;
  assign bus.ram_we    = w_issue_wr;
  // Address/data hold their last issued value between beats.
  assign bus.ram_addr  = w_issue ? r_addr : r_ram_addr;
  assign bus.ram_din   = w_issue_wr ? w_wr_din : r_ram_din;
  assign bus.rsp_valid = (w_fifo_count != 2'd0);
  assign bus.rsp_data  = w_head.data;
  assign bus.rsp_last  = w_head.last;
  assign bus.rsp_err   = w_head.err;
  assign bus.busy      = (r_state != IDLE) | r_inflight | (w_fifo_count != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_blk_ram_burst_initiator.sv
`default_nettype none
// ============================================================================
// Module : tb_blk_ram_burst_initiator
// Brief  : Self-checking bench: behavioural RAM, shadow memory and response
//          scoreboard for blk_ram_burst_initiator.
// Rev    : 1.0  initial release
// ============================================================================
module tb_blk_ram_burst_initiator;

  typedef struct {
    logic [8:0] data;
    logic       last;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic reset_l = 1'b0;
  always #5 clk = ~clk;

  blk_ram_burst_initiator_if bus ();

  blk_ram_burst_initiator dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus)
  );

  bit   [8:0] ram     [0:131071];
  bit   [8:0] ref_mem [0:131071];
  bit   [8:0] ram_q;
  logic       flip_b0 = 1'b0;
  int         n_total = 0;
  int         n_bad   = 0;
  int         n_rx    = 0;
  int         rdy_mode = 0;
  exp_t       exp_q[$];
  logic [8:0] wdata_q[$];

  // Behavioural single-port RAM, 1-cycle read latency.
  assign bus.ram_dout = ram_q ^ {8'd0, flip_b0};
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) ram[bus.ram_addr] = bus.ram_din;
      else            ram_q <= ram[bus.ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] exp_rd(input logic [8:0] d);
`ifdef RAM_PARITY_EN
    return {1'b0, d[7:0]};
`else
    return d;
`endif
  endfunction

  function automatic logic [8:0] exp_din(input logic [8:0] d);
`ifdef RAM_PARITY_EN
    return {^d[7:0], d[7:0]};
`else
    return d;
`endif
  endfunction

  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.rsp_ready = 1'b1;
        1:       bus.rsp_ready = 1'($urandom_range(0, 1));
        default: bus.rsp_ready = 1'b0;
      endcase
    end
  end

  // Response scoreboard: order, data, last, err and hold-under-back-pressure.
  initial begin
    logic       prev_stall;
    logic [8:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!reset_l) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("rsp_hold_valid", bus.rsp_valid, 1);
          chk("rsp_hold_data", bus.rsp_data, prev_data);
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("rsp_extra", bus.rsp_valid, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_data", bus.rsp_data, e.data);
            chk("rsp_last", bus.rsp_last, e.last);
            chk("rsp_err", bus.rsp_err, e.err);
            n_rx++;
          end
        end
        prev_stall = bus.rsp_valid && !bus.rsp_ready;
        prev_data  = bus.rsp_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic send_req(input logic wr, input logic [16:0] a, input int nb, input logic flip);
    int g;
    bit done;
    g    = 0;
    done = 0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_len   = 8'(nb - 1);
    while (!done && g < 200) begin
      @(negedge clk);
      if (bus.req_ready) begin
        done = 1;
        if (!wr) begin
          for (int i = 0; i < nb; i++) begin
            logic [16:0] ai;
            logic [8:0]  d;
            ai = a + 17'(i);
            d  = ref_mem[ai] ^ {8'd0, flip};
            exp_q.push_back('{data: exp_rd(d), last: (i == nb - 1), err: flip});
          end
        end
      end
      @(posedge clk);
      #1;
      g++;
    end
    bus.req_valid = 1'b0;
    if (!done) chk("req_timeout", bus.req_ready, 1);
  endtask

  task automatic read_burst(input logic [16:0] a, input int nb, input logic flip);
    flip_b0 = flip;
    send_req(1'b0, a, nb, flip);
  endtask

  // gap: 0 = continuous, 1 = valid on alternate cycles, 2 = random gaps
  task automatic write_burst(input logic [16:0] a, input int nb, input int gap);
    int          i;
    int          g;
    logic [8:0]  d;
    logic [16:0] ea;
    i = 0;
    g = 0;
    send_req(1'b1, a, nb, 1'b0);
    while (i < nb && g < 1000) begin
      d = wdata_q[i];
      bus.wr_data = d;
      case (gap)
        0:       bus.wr_valid = 1'b1;
        1:       bus.wr_valid = (g % 2 == 0);
        default: bus.wr_valid = ($urandom_range(0, 3) != 0);
      endcase
      @(negedge clk);
      chk("wr_we", bus.ram_we, bus.wr_valid);
      if (bus.wr_valid && bus.wr_ready) begin
        ea = a + 17'(i);
        chk("wr_addr", bus.ram_addr, ea);
        chk("wr_din", bus.ram_din, exp_din(d));
        ref_mem[ea] = d;
        i++;
      end
      @(posedge clk);
      #1;
      g++;
    end
    bus.wr_valid = 1'b0;
    if (i < nb) chk("wr_timeout", i, nb);
    @(negedge clk);
    chk("wr_idle_req_ready", bus.req_ready, 1);
    chk("wr_idle_wr_ready", bus.wr_ready, 0);
    @(posedge clk);
    #1;
    wdata_q.delete();
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || bus.busy) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_busy", bus.busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [16:0] a;
    int          n;
    int          en_cnt;
    int          rx0;
    logic [8:0]  h0;

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    reset_l       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    @(posedge clk);
    #1;
    reset_l = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", bus.req_ready, 1);
    chk("idle_wr_ready", bus.wr_ready, 0);
    @(posedge clk);
    #1;

    // Basic write then read with latency check
    for (int i = 1; i <= 4; i++) wdata_q.push_back(9'(i));
    write_burst(17'h00010, 4, 0);
    read_burst(17'h00010, 4, 1'b0);
    @(negedge clk);
    chk("lat_ram_en", bus.ram_en, 1);
    chk("lat_rsp_n1", bus.rsp_valid, 0);
    @(negedge clk);
    chk("lat_rsp_n2", bus.rsp_valid, 0);
    @(negedge clk);
    chk("lat_rsp_n3", bus.rsp_valid, 1);
    chk("lat_first_data", bus.rsp_data, 9'h001);
    @(posedge clk);
    #1;
    drain();

    // Back-pressure: only two reads outstanding, head held
    a = 17'($urandom);
    for (int i = 0; i < 8; i++) wdata_q.push_back(9'($urandom));
    write_burst(a, 8, 0);
    rdy_mode = 2;
    @(posedge clk);
    #1;
    read_burst(a, 8, 1'b0);
    h0     = exp_q[0].data;
    en_cnt = 0;
    rx0    = n_rx;
    repeat (10) begin
      @(negedge clk);
      if (bus.ram_en) en_cnt++;
      if (bus.rsp_valid) chk("bp_head", bus.rsp_data, h0);
    end
    chk("bp_ram_en", en_cnt, 2);
    @(posedge clk);
    #1;
    rdy_mode = 0;
    drain();
    chk("bp_beats", n_rx - rx0, 8);

    // Address wrap
    for (int i = 0; i < 3; i++) wdata_q.push_back(9'($urandom));
    write_burst(17'h1FFFE, 3, 0);
    read_burst(17'h1FFFE, 3, 1'b0);
    drain();

    // Gapped write beats
    a = 17'($urandom);
    for (int i = 0; i < 3; i++) wdata_q.push_back(9'($urandom));
    write_burst(a, 3, 1);
    read_burst(a, 3, 1'b0);
    drain();

    // Reset in the middle of a stalled read
    rdy_mode = 2;
    @(posedge clk);
    #1;
    read_burst(17'($urandom), 16, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_pre_valid", bus.rsp_valid, 1);
    @(posedge clk);
    #1;
    reset_l = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_l = 1'b1;
    @(negedge clk);
    chk("rst_mid_rsp_valid", bus.rsp_valid, 0);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_req_ready", bus.req_ready, 1);
    en_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.ram_en) en_cnt++;
    end
    chk("rst_mid_no_en", en_cnt, 0);
    @(posedge clk);
    #1;
    rdy_mode = 0;

`ifdef RAM_PARITY_EN
    wdata_q.push_back(9'h0A5);
    write_burst(17'h00100, 1, 0);
    read_burst(17'h00100, 1, 1'b1);
    drain();
    flip_b0 = 1'b0;
    read_burst(17'h00100, 1, 1'b0);
    drain();
`endif

    // Randomized mix; reads are not drained between requests
    for (int k = 0; k < 40; k++) begin
      rdy_mode = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) a = 17'h1FFF0 + 17'($urandom_range(0, 15));
      else                           a = 17'($urandom);
      n = (k == 7) ? 256 : $urandom_range(1, 12);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n; i++) wdata_q.push_back(9'($urandom));
        write_burst(a, n, 2);
      end else begin
        read_burst(a, n, 1'b0);
      end
    end
    rdy_mode = 0;
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
